pcpi_fsubs: RTL and testbench

PCPI_FSUBS -- requirements
Module: pcpi_fsubs

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_unpack.sv | 23 ++
 rtl/pcpi_fsubs.sv | 199 +++++++++++++++++++
 tb/tb_pcpi_fsubs.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision subtract coprocessor.
//   - IEEE-754 single field widths and exponent bias
//   - custom-instruction decode constants (opcode / funct7 of FSUB)
//   - FSM state encoding
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int SIG_W  = MANT_W + 1;  // mantissa including the hidden bit
  localparam int BIAS   = 127;

  // All-ones exponent: reaching it means the result is infinite.
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

  localparam logic [6:0] OPCODE      = 7'b1010011;
  localparam logic [6:0] FUNCT7_FSUB = 7'b0000100;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ARITH,
    NORM,
    DONE
  } state_t;

  // Only the opcode and funct7 fields select the instruction.
  function automatic logic is_fsub(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE) && (funct7 == FUNCT7_FSUB);
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into sign, exponent and 24-bit significand.
// Denormals are flushed: exponent 0 yields a zero significand and sets zero.
//   word : packed single-precision operand
//   sign : sign bit
//   exp  : biased exponent
//   mant : significand with hidden bit (0 when zero is set)
//   zero : operand treated as zero
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]      word,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [SIG_W-1:0] mant,
  output logic             zero
);

  assign sign = word[31];
  assign exp  = word[MANT_W +: EXP_W];
  assign zero = (exp == '0);
  assign mant = zero ? '0 : {1'b1, word[MANT_W-1:0]};

endmodule

// File: rtl/pcpi_fsubs.sv
// PCPI coprocessor computing rd = rs1 - rs2 in IEEE-754 single precision.
// Multi-cycle: IDLE -> ALIGN -> ARITH -> NORM (one left shift per cycle) -> DONE.
// Denormal inputs are flushed to zero, rounding is truncation, underflow
// flushes to a signed zero and exponent overflow yields a signed infinity.
//   clk        : clock, all state changes on the rising edge
//   resetn     : synchronous active-low reset
//   pcpi_valid : core offers an instruction (held until pcpi_ready)
//   pcpi_insn  : instruction word
//   pcpi_rs1   : operand a
//   pcpi_rs2   : operand b
//   pcpi_wr    : result write enable, pulses with pcpi_ready
//   pcpi_rd    : result a - b, zero outside DONE
//   pcpi_wait  : busy while ALIGN / ARITH / NORM
//   pcpi_ready : one-cycle completion pulse
module pcpi_fsubs
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  state_t state, state_next;

  logic [31:0] rs1_q, rs2_q;

  // Datapath registers shared across the pipeline steps of one operation.
  logic [SIG_W-1:0] mant_big, mant_small, mant_r;
  logic [EXP_W-1:0] exp_r;
  logic             sign_r;
  logic             eff_sub;

  logic accept;
  logic unused_insn_bits;

  assign accept           = pcpi_valid && is_fsub(pcpi_insn[6:0], pcpi_insn[31:25]);
  assign unused_insn_bits = ^pcpi_insn[24:7];

  // ---------------------------------------------------------------- ALIGN
  logic             a_sign, b_sign, a_zero, b_zero;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [SIG_W-1:0] a_mant, b_mant;

  fp_unpack u_unpack_a (
    .word (rs1_q),
    .sign (a_sign),
    .exp  (a_exp),
    .mant (a_mant),
    .zero (a_zero)
  );

  fp_unpack u_unpack_b (
    .word (rs2_q),
    .sign (b_sign),
    .exp  (b_exp),
    .mant (b_mant),
    .zero (b_zero)
  );

  logic             a_ge_b;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
  logic [SIG_W-1:0] big_mant, small_mant, small_aligned;
  logic             small_zero;

  // Ordering by {exp, mant} puts the larger magnitude first, so the
  // exponent difference is never negative and subtraction never borrows.
  assign a_ge_b        = {a_exp, a_mant} >= {b_exp, b_mant};
  assign big_exp       = a_ge_b ? a_exp  : b_exp;
  assign small_exp     = a_ge_b ? b_exp  : a_exp;
  assign big_mant      = a_ge_b ? a_mant : b_mant;
  assign small_mant    = a_ge_b ? b_mant : a_mant;
  assign small_zero    = a_ge_b ? b_zero : a_zero;
  assign exp_diff      = big_exp - small_exp;
  assign small_aligned = (small_zero || exp_diff >= EXP_W'(SIG_W)) ? '0
                                                                    : (small_mant >> exp_diff);

  // ---------------------------------------------------------------- ARITH
  logic [SIG_W:0]   sum;
  logic [EXP_W:0]   exp_inc;
  logic             overflow;

  assign sum      = eff_sub ? ({1'b0, mant_big} - {1'b0, mant_small})
                            : ({1'b0, mant_big} + {1'b0, mant_small});
  assign exp_inc  = {1'b0, exp_r} + (EXP_W+1)'(1);
  assign overflow = sum[SIG_W] && (exp_inc >= {1'b0, EXP_MAX});

  // ----------------------------------------------------------------- NORM
  logic need_shift, underflow;

  assign need_shift = (mant_r != '0) && !mant_r[SIG_W-1];
  assign underflow  = need_shift && (exp_r <= EXP_W'(1));

  // ------------------------------------------------- next state / outputs
  // NOTE: every output and state_next gets a default first so no path
  // through the case leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    unique case (state)
      IDLE:  if (accept) state_next = ALIGN;
      ALIGN: begin
        pcpi_wait  = 1'b1;
        state_next = ARITH;
      end
      ARITH: begin
        pcpi_wait  = 1'b1;
        state_next = overflow ? DONE : NORM;
      end
      NORM: begin
        pcpi_wait  = 1'b1;
        state_next = (need_shift && !underflow) ? NORM : DONE;
      end
      DONE: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = {sign_r, exp_r, mant_r[MANT_W-1:0]};
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------ registers
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others regardless of order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: datapath registers are cleared too, so an operation aborted
      // by reset leaves no stale operand or partial result behind.
      state      <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      mant_big   <= '0;
      mant_small <= '0;
      mant_r     <= '0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      eff_sub    <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (accept) begin
            rs1_q <= pcpi_rs1;
            rs2_q <= pcpi_rs2;
          end
        end
        ALIGN: begin
          mant_big   <= big_mant;
          mant_small <= small_aligned;
          exp_r      <= big_exp;
          sign_r     <= a_ge_b ? a_sign : ~b_sign;
          // a - b with equal signs is a magnitude subtraction.
          eff_sub    <= (a_sign == b_sign);
        end
        ARITH: begin
          if (sum == '0) begin
            // Exact cancellation always gives +0.
            mant_r <= '0;
            exp_r  <= '0;
            sign_r <= 1'b0;
          end else if (sum[SIG_W]) begin
            if (overflow) begin
              mant_r <= '0;
              exp_r  <= EXP_MAX;
            end else begin
              mant_r <= sum[SIG_W:1];
              exp_r  <= exp_inc[EXP_W-1:0];
            end
          end else begin
            mant_r <= sum[SIG_W-1:0];
          end
        end
        NORM: begin
          if (underflow) begin
            // Sign is kept: underflow gives a signed zero.
            mant_r <= '0;
            exp_r  <= '0;
          end else if (need_shift) begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_r - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_fsubs.sv
// Directed testbench for pcpi_fsubs: hand-computed single-precision
// subtraction results, latency / busy-cycle counts, decode rejection and
// reset abort in the middle of normalisation.
module tb_pcpi_fsubs;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  localparam logic [31:0] FSUB       = 32'h0800_0053;
  localparam logic [31:0] FSUB_NOISY = 32'h08FF_FFD3;  // don't-care fields set
  localparam logic [31:0] NOT_FSUB   = 32'h0000_0053;  // funct7 = 0

  pcpi_fsubs dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge. Offers one instruction, counts cycles
  // until ready (cycle 0 = the cycle valid is first sampled), then checks
  // the result, busy cycles and the return to idle.
  task automatic run_op(input string tag, input logic [31:0] insn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input int exp_lat,
                        input bit drop_valid);
    int cyc   = 0;
    int waits = 0;
    int leaks = 0;
    bit done  = 1'b0;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (pcpi_ready) begin
        done = 1'b1;
      end else begin
        if (pcpi_wait) waits++;
        if (pcpi_rd != 32'h0 || pcpi_wr) leaks++;
      end
      if (drop_valid && cyc == 1) begin
        pcpi_valid = 1'b0;
        pcpi_rs1   = 32'hDEAD_BEEF;
        pcpi_rs2   = 32'h1234_5678;
      end
    end
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " rd"}, pcpi_rd, exp_rd);
    check({tag, " wr"}, {31'b0, pcpi_wr}, 32'd1);
    check({tag, " wait cycles"}, waits, exp_lat - 1);
    check({tag, " rd/wr before done"}, leaks, 0);
    pcpi_valid = 1'b0;
    @(negedge clk);
    check({tag, " idle after"}, {28'b0, pcpi_ready, pcpi_wr, pcpi_wait, |pcpi_rd}, 32'd0);
  endtask

  initial begin
    int busy;
    resetn     = 1'b0;
    // An FSUB offered during reset must not start.
    pcpi_valid = 1'b1;
    pcpi_insn  = FSUB;
    pcpi_rs1   = 32'h4040_0000;
    pcpi_rs2   = 32'h3F80_0000;
    repeat (3) @(negedge clk);
    check("reset ctl", {29'b0, pcpi_ready, pcpi_wr, pcpi_wait}, 32'd0);
    check("reset rd", pcpi_rd, 32'h0);

    // First edge with resetn high accepts the instruction.
    resetn = 1'b1;
    run_op("3-1",          FSUB,       32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 1'b0);
    run_op("1-0.75",       FSUB,       32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6, 1'b0);
    run_op("1-1",          FSUB,       32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4, 1'b0);
    run_op("1-(-1)",       FSUB,       32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4, 1'b0);
    run_op("1-3",          FSUB,       32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 4, 1'b0);
    run_op("noisy insn",   FSUB_NOISY, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 1'b0);
    run_op("valid drop",   FSUB,       32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6, 1'b1);
    run_op("overflow",     FSUB,       32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 3, 1'b0);
    run_op("denorm flush", FSUB,       32'h0040_0000, 32'h3F80_0000, 32'hBF80_0000, 4, 1'b0);
    run_op("diff>=24",     FSUB,       32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000, 4, 1'b0);
    run_op("truncate",     FSUB,       32'h3F80_0000, 32'hB440_0000, 32'h3F80_0001, 4, 1'b0);
    run_op("underflow",    FSUB,       32'h0080_0000, 32'h00C0_0000, 32'h8000_0000, 4, 1'b0);

    // Non-matching funct7 held for 10 cycles: nothing may happen.
    busy       = 0;
    pcpi_valid = 1'b1;
    pcpi_insn  = NOT_FSUB;
    pcpi_rs1   = 32'h4040_0000;
    pcpi_rs2   = 32'h3F80_0000;
    repeat (10) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready || pcpi_wr) busy++;
    end
    pcpi_valid = 1'b0;
    check("no match quiet", busy, 0);

    // Reset while normalising 1.0 - 0.75 aborts without a ready pulse.
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = FSUB;
    pcpi_rs1   = 32'h3F80_0000;
    pcpi_rs2   = 32'h3F40_0000;
    repeat (4) @(negedge clk);
    check("busy in norm", {31'b0, pcpi_wait}, 32'd1);
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    @(negedge clk);
    check("abort ctl", {29'b0, pcpi_ready, pcpi_wr, pcpi_wait}, 32'd0);
    check("abort rd", pcpi_rd, 32'h0);
    resetn = 1'b1;
    busy   = 0;
    repeat (8) begin
      @(negedge clk);
      if (pcpi_ready || pcpi_wr || pcpi_wait) busy++;
    end
    check("no ready after abort", busy, 0);
    run_op("3-1 after abort", FSUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
